syscall_display: RTL and testbench
==================================

// Module: syscall_display
// PURPOSE
//  Consumer end of the CPU's syscall print path. Captures each printed word (display_syscall),
//  or the live PC on request, and drives a time-multiplexed 8-digit active-low 7-segment display.
//  Scans digits with inter-digit ghost blanking, suppresses leading zeros, blinks after CPU halt.
//  Sits at board top level between cpu and the display pins.
// PARAMETERS
//  CLK_HZ      100_000_000  system clock frequency
//  REFRESH_HZ  1000         full-frame refresh rate; DIV = CLK_HZ/(REFRESH_HZ*NUM_DIGITS) cycles per digit
//  NUM_DIGITS  8            hex digits shown (value nibble i -> digit i, digit 0 = LSB)
//  BLANK_CYC   4            all-anodes-off cycles before each digit is driven; requires 1 <= BLANK_CYC < DIV
//  BLINK_HZ    2            halt blink rate; half-period HP = CLK_HZ/(2*BLINK_HZ) cycles
//  LZ_BLANK    1            1 = blank leading-zero digits
// PORTS
//  clk          in   1           system clock, rising edge
//  rst_n        in   1           asynchronous, active-low reset
//  value_in     in   32          word to print (cpu display_syscall)
//  value_valid  in   1           1-cycle strobe: value_in is a new printed word
//  pc_in        in   15          current PC (cpu display_pc)
//  halt         in   1           CPU halt indication
//  mode_sel     in   1           0 = show captured value, 1 = show PC
//  seg_n        out  8           [6:0] = g..a, [7] = dp, active-low
//  an_n         out  NUM_DIGITS  digit anodes, active-low, at most one low
//  print_cnt    out  8           count of accepted prints
// BEHAVIOUR
//  Reset (async assert, sync release): seg_n=8'hFF, an_n=all 1, print_cnt=0, shadow=0, halted=0,
//   digit idx=0, prescaler=0, blink phase=on, FSM=BLANK with blank count 0.
//  Capture: value_valid=1 and halt=0 -> shadow<=value_in and print_cnt<=print_cnt+1 next edge.
//   print_cnt wraps 255->0. value_valid with halt=1 is ignored (halt has priority).
//  PC path: pc_in registered every cycle, zero-extended to 32 bits.
//  Source select: mode_sel is sampled only at digit ticks; a change never alters a digit mid-drive.
//  Prescaler: counts 0..DIV-1 and wraps. tick when prescaler==DIV-1.
//  Scan FSM:
//   - BLANK: an_n=all 1, seg_n=8'hFF. After BLANK_CYC cycles, go to DRIVE.
//   - DRIVE: an_n=~(1<<idx), seg_n=encode(nibble idx). Outputs are registered and change one cycle after entering DRIVE.
//   - tick in any state: idx <= (idx==NUM_DIGITS-1) ? 0 : idx+1, FSM -> BLANK, blank count cleared.
//  Leading-zero blank (LZ_BLANK=1): digit i>0 blanks (seg_n=8'hFF, anode still driven) when nibbles i..NUM_DIGITS-1 are all 0.
//   Value 0 shows a single "0" on digit 0.
//  Encoding: 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 A=88 b=83 C=C6 d=A1 E=86 F=8E (dp off).
//  Halt:
//   - halt sampled 1 sets sticky halted, which clears only on reset.
//   - While halted: blink counter toggles phase every HP cycles; phase off forces an_n=all 1.
//   - dp of digit 0 lit (seg_n[7]=0) while halted.
//  Simultaneous: tick coinciding with value_valid -> new digit uses the pre-capture shadow; the capture is seen from the next tick on.
//  rst_n low mid-scan: all outputs return to reset values immediately, with no further anode pulses.
// STRUCTURE
//  disp_pkg: scan_state_t enum {BLANK, DRIVE}, SEG_* encoding constants, function hex_to_seg_f.
//  Sub-module hex_to_seg (combinational nibble -> 7-bit segments). All counters and FSM in syscall_display.
//  Bench params: CLK_HZ=800, REFRESH_HZ=10, NUM_DIGITS=8 (DIV=10), BLANK_CYC=2, BLINK_HZ=20 (HP=20).
// TESTING
//  1 Reset, no input -> first DRIVE: an_n=8'hFE, seg_n=C0. Digits 1..7 blank (FF), anodes walk FD..7F every 10 cycles.
//  2 value_valid with value_in=32'h0000_1AF0 -> digits 0..3 show C0,8E,88,F9. Digits 4..7 show FF. print_cnt=1.
//  3 256 strobes -> print_cnt wraps to 0. Strobe with halt=1 -> shadow and print_cnt unchanged.
//  4 mode_sel=1, pc_in=15'h0040, flipped mid-digit -> current digit unchanged; from next tick digit1=99, digit0=C0.
//  5 halt pulse -> digit0 dp lit (seg_n=40 for "0"); an_n forced all 1 for 20 of every 40 cycles; persists after halt=0.
//  6 rst_n low during DRIVE -> same cycle an_n=FF, seg_n=FF, print_cnt=0. Every scan: check at most one an_n bit low, and >=2 all-off cycles between digits.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared types and segment encodings for the syscall display path.
package disp_pkg;

    typedef enum logic {
        BLANK = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

    // Active-low segment patterns, bit 7 = dp (off), bits 6..0 = g..a.
    localparam logic [7:0] SEG_0   = 8'hC0;
    localparam logic [7:0] SEG_1   = 8'hF9;
    localparam logic [7:0] SEG_2   = 8'hA4;
    localparam logic [7:0] SEG_3   = 8'hB0;
    localparam logic [7:0] SEG_4   = 8'h99;
    localparam logic [7:0] SEG_5   = 8'h92;
    localparam logic [7:0] SEG_6   = 8'h82;
    localparam logic [7:0] SEG_7   = 8'hF8;
    localparam logic [7:0] SEG_8   = 8'h80;
    localparam logic [7:0] SEG_9   = 8'h90;
    localparam logic [7:0] SEG_A   = 8'h88;
    localparam logic [7:0] SEG_B   = 8'h83;
    localparam logic [7:0] SEG_C   = 8'hC6;
    localparam logic [7:0] SEG_D   = 8'hA1;
    localparam logic [7:0] SEG_E   = 8'h86;
    localparam logic [7:0] SEG_F   = 8'h8E;
    localparam logic [7:0] SEG_OFF = 8'hFF;

    function automatic logic [6:0] hex_to_seg_f(input logic [3:0] nib);
        logic [7:0] s;
        case (nib)
            4'h0:    s = SEG_0;
            4'h1:    s = SEG_1;
            4'h2:    s = SEG_2;
            4'h3:    s = SEG_3;
            4'h4:    s = SEG_4;
            4'h5:    s = SEG_5;
            4'h6:    s = SEG_6;
            4'h7:    s = SEG_7;
            4'h8:    s = SEG_8;
            4'h9:    s = SEG_9;
            4'hA:    s = SEG_A;
            4'hB:    s = SEG_B;
            4'hC:    s = SEG_C;
            4'hD:    s = SEG_D;
            4'hE:    s = SEG_E;
            default: s = SEG_F;
        endcase
        return s[6:0];
    endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex nibble to active-low g..a segment decoder.
module hex_to_seg
    import disp_pkg::*;
(
    input  logic [3:0] i_nib,
    output logic [6:0] o_seg
);

    assign o_seg = hex_to_seg_f(i_nib);

endmodule

// File: rtl/syscall_display.sv
// Syscall print sink: captures printed words / PC and scans them onto an
// 8-digit multiplexed active-low 7-segment display with blanking and halt blink.
module syscall_display
    import disp_pkg::*;
#(
    parameter int CLK_HZ     = 100_000_000,
    parameter int REFRESH_HZ = 1000,
    parameter int NUM_DIGITS = 8,
    parameter int BLANK_CYC  = 4,
    parameter int BLINK_HZ   = 2,
    parameter int LZ_BLANK   = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [31:0]           value_in,
    input  logic                  value_valid,
    input  logic [14:0]           pc_in,
    input  logic                  halt,
    input  logic                  mode_sel,
    output logic [7:0]            seg_n,
    output logic [NUM_DIGITS-1:0] an_n,
    output logic [7:0]            print_cnt
);

    localparam int DIV = CLK_HZ / (REFRESH_HZ * NUM_DIGITS);
    localparam int HP  = CLK_HZ / (2 * BLINK_HZ);
    localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int BW  = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;
    localparam int HW  = (HP > 1) ? $clog2(HP) : 1;

    logic [31:0]           r_shadow;
    logic [7:0]            r_print_cnt;
    logic                  r_halted;
    logic [14:0]           r_pc;
    logic [31:0]           r_word;
    logic [PW-1:0]         r_presc;
    logic [IW-1:0]         r_idx;
    logic [BW-1:0]         r_blank_cnt;
    logic [HW-1:0]         r_blink_cnt;
    logic                  r_phase_on;
    scan_state_t           r_state;
    logic [NUM_DIGITS-1:0] r_an_n;
    logic [7:0]            r_seg_n;

    logic                  w_tick;
    scan_state_t           w_state_nxt;
    logic [BW-1:0]         w_blank_nxt;
    logic [31:0]           w_shifted;
    logic [3:0]            w_nib;
    logic [6:0]            w_seg7;
    logic                  w_lz_blank;
    logic [NUM_DIGITS-1:0] w_an_nxt;
    logic [7:0]            w_seg_nxt;

    assign w_tick     = (r_presc == PW'(DIV - 1));
    assign w_shifted  = r_word >> {r_idx, 2'b00};
    assign w_nib      = w_shifted[3:0];
    assign w_lz_blank = (LZ_BLANK != 0) && (r_idx != '0) && (w_shifted == 32'd0);

    hex_to_seg u_hex_to_seg (
        .i_nib (w_nib),
        .o_seg (w_seg7)
    );

    // Capture printed words (halt wins over a strobe), track PC and sticky halt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_shadow    <= '0;
            r_print_cnt <= '0;
            r_halted    <= 1'b0;
            r_pc        <= '0;
        end else begin
            r_pc <= pc_in;
            if (halt) begin
                r_halted <= 1'b1;
            end
            if (value_valid && !halt) begin
                r_shadow    <= value_in;
                r_print_cnt <= r_print_cnt + 8'd1;
            end
        end
    end

    // Digit prescaler; at each tick advance the digit and latch its source word
    // so the source (and any new capture) only takes effect on a digit boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_idx   <= '0;
            r_word  <= '0;
        end else begin
            r_presc <= w_tick ? '0 : r_presc + PW'(1);
            if (w_tick) begin
                r_idx  <= (r_idx == IW'(NUM_DIGITS - 1)) ? '0 : r_idx + IW'(1);
                r_word <= mode_sel ? {17'd0, r_pc} : r_shadow;
            end
        end
    end

    // Halt blink: phase toggles every HP cycles once halted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_blink_cnt <= '0;
            r_phase_on  <= 1'b1;
        end else if (r_halted) begin
            if (r_blink_cnt == HW'(HP - 1)) begin
                r_blink_cnt <= '0;
                r_phase_on  <= ~r_phase_on;
            end else begin
                r_blink_cnt <= r_blink_cnt + HW'(1);
            end
        end
    end

    // Scan FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= BLANK;
            r_blank_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_blank_cnt <= w_blank_nxt;
        end
    end

    // Scan FSM next state: blank for BLANK_CYC cycles, then drive until the tick.
    always_comb begin
        w_state_nxt = r_state;
        w_blank_nxt = r_blank_cnt;
        if (w_tick) begin
            w_state_nxt = BLANK;
            w_blank_nxt = '0;
        end else if (r_state == BLANK) begin
            if (r_blank_cnt == BW'(BLANK_CYC - 1)) begin
                w_state_nxt = DRIVE;
                w_blank_nxt = '0;
            end else begin
                w_blank_nxt = r_blank_cnt + BW'(1);
            end
        end
    end

    // Next anode/segment pattern for the digit currently being driven.
    always_comb begin
        w_an_nxt  = '1;
        w_seg_nxt = SEG_OFF;
        if (r_state == DRIVE) begin
            if (!(r_halted && !r_phase_on)) begin
                w_an_nxt = ~(NUM_DIGITS'(1) << r_idx);
            end
            w_seg_nxt[6:0] = w_lz_blank ? 7'h7F : w_seg7;
            w_seg_nxt[7]   = ~(r_halted && (r_idx == '0));
        end
    end

    // Registered display pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_an_n  <= '1;
            r_seg_n <= SEG_OFF;
        end else begin
            r_an_n  <= w_an_nxt;
            r_seg_n <= w_seg_nxt;
        end
    end

    assign an_n      = r_an_n;
    assign seg_n     = r_seg_n;
    assign print_cnt = r_print_cnt;

endmodule

// File: tb/tb_syscall_display.sv
// Self-checking bench for syscall_display with a timing-arithmetic reference model.
module tb_syscall_display;

    localparam int DIV = 10;
    localparam int HP  = 20;
    localparam int ND  = 8;
    localparam int BC  = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [31:0] value_in;
    logic        value_valid;
    logic [14:0] pc_in;
    logic        halt;
    logic        mode_sel;
    logic [7:0]  seg_n;
    logic [7:0]  an_n;
    logic [7:0]  print_cnt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    syscall_display #(
        .CLK_HZ     (800),
        .REFRESH_HZ (10),
        .NUM_DIGITS (8),
        .BLANK_CYC  (2),
        .BLINK_HZ   (20),
        .LZ_BLANK   (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .value_in    (value_in),
        .value_valid (value_valid),
        .pc_in       (pc_in),
        .halt        (halt),
        .mode_sel    (mode_sel),
        .seg_n       (seg_n),
        .an_n        (an_n),
        .print_cnt   (print_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: output after edge n reflects cycle c=n-1 of the scan,
    // where slot = c/DIV selects the digit and the first BC cycles of a slot are dark.
    logic [7:0]  enc [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                              8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    int          m_cyc = 0;
    int          m_hcyc = 0;
    int          m_pos, m_idx;
    logic [31:0] m_shadow = 0, m_word = 0, m_upper;
    logic [14:0] m_pc = 0;
    logic [7:0]  m_cnt = 0, m_pat;
    logic        m_halted = 0;
    logic [7:0]  e_an = 8'hFF, e_seg = 8'hFF, e_cnt = 8'h00;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_cyc = 0; m_hcyc = 0; m_shadow = 0; m_word = 0; m_pc = 0;
            m_cnt = 0; m_halted = 0; e_an = 8'hFF; e_seg = 8'hFF; e_cnt = 8'h00;
        end else begin
            m_pos   = m_cyc % DIV;
            m_idx   = (m_cyc / DIV) % ND;
            m_upper = m_word >> (4 * m_idx);
            if (m_pos >= BC) begin
                m_pat = enc[m_upper[3:0]];
                if (m_idx != 0 && m_upper == 0) m_pat = 8'hFF;
                if (m_halted && m_idx == 0) m_pat[7] = 1'b0;
                e_seg = m_pat;
                e_an  = (!m_halted || ((m_hcyc / HP) % 2 == 0)) ? ~(8'h01 << m_idx) : 8'hFF;
            end else begin
                e_seg = 8'hFF;
                e_an  = 8'hFF;
            end
            if (m_pos == DIV - 1) m_word = mode_sel ? {17'd0, m_pc} : m_shadow;
            m_pc = pc_in;
            if (m_halted) m_hcyc++;
            if (halt) m_halted = 1'b1;
            if (value_valid && !halt) begin
                m_shadow = value_in;
                m_cnt    = m_cnt + 8'd1;
            end
            e_cnt = m_cnt;
            m_cyc++;
        end
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Every-cycle compare plus anode one-hot and inter-digit dark-gap checks.
    logic [7:0] last_an = 8'hFF;
    int         off_run = 0;
    always @(negedge clk) begin
        chk("model_an_n", an_n, e_an);
        chk("model_seg_n", seg_n, e_seg);
        chk("model_print_cnt", print_cnt, e_cnt);
        chk("an_onehot", ($countones(~an_n) <= 1), 1);
        if (!rst_n) begin
            last_an = 8'hFF;
            off_run = 0;
        end else if (an_n == 8'hFF) begin
            off_run++;
        end else begin
            if (last_an != 8'hFF && an_n != last_an) chk("digit_gap_ge2", (off_run >= 2), 1);
            last_an = an_n;
            off_run = 0;
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        value_valid = 0; value_in = 0; halt = 0; mode_sel = 0; pc_in = 0;
        repeat (3) @(negedge clk);
        chk("rst_an_n", an_n, 8'hFF);
        chk("rst_seg_n", seg_n, 8'hFF);
        chk("rst_print_cnt", print_cnt, 8'h00);
        rst_n = 1'b1;
    endtask

    // Wait for a fresh appearance of anode pattern tgt, then pin its segments.
    task automatic wait_digit(input string nm, input logic [7:0] tgt, input logic [7:0] seg_exp);
        int n = 0;
        while (an_n == tgt && n < 300) begin @(negedge clk); n++; end
        while (an_n != tgt && n < 300) begin @(negedge clk); n++; end
        chk({nm, "_an"}, an_n, tgt);
        chk({nm, "_seg"}, seg_n, seg_exp);
    endtask

    int n, b0, b1, b2, n_on;

    initial begin
        #200000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        value_in = 0; value_valid = 0; pc_in = 0; halt = 0; mode_sel = 0;
        #1 rst_n = 1'b0;
        do_reset();

        // 1: idle display shows a single 0 and walks the anodes
        n = 0;
        while (an_n == 8'hFF && n < 40) begin @(negedge clk); n++; end
        chk("t1_first_drive_latency", cyc, 3);
        chk("t1_d0_an", an_n, 8'hFE);
        chk("t1_d0_seg", seg_n, 8'hC0);
        wait_digit("t1_d1", 8'hFD, 8'hFF);
        wait_digit("t1_d7", 8'h7F, 8'hFF);

        // 2: capture 0x1AF0
        value_in = 32'h0000_1AF0; value_valid = 1;
        @(negedge clk);
        value_valid = 0;
        chk("t2_print_cnt", print_cnt, 8'd1);
        wait_digit("t2_d7", 8'h7F, 8'hFF);
        wait_digit("t2_d0", 8'hFE, 8'hC0);
        wait_digit("t2_d1", 8'hFD, 8'h8E);
        wait_digit("t2_d2", 8'hFB, 8'h88);
        wait_digit("t2_d3", 8'hF7, 8'hF9);
        wait_digit("t2_d4", 8'hEF, 8'hFF);

        // 3: 255 more strobes wrap the count to 0, one more makes it 1
        value_valid = 1;
        repeat (255) @(negedge clk);
        value_valid = 0;
        chk("t3_wrap", print_cnt, 8'd0);
        value_valid = 1;
        @(negedge clk);
        value_valid = 0;
        chk("t3_after_wrap", print_cnt, 8'd1);

        // 4: switch to PC mid-digit; the digit in flight keeps its value
        pc_in = 15'h0040;
        wait_digit("t4_d1_pre", 8'hFD, 8'h8E);
        repeat (2) @(negedge clk);
        mode_sel = 1;
        repeat (2) @(negedge clk);
        chk("t4_mid_an", an_n, 8'hFD);
        chk("t4_mid_seg", seg_n, 8'h8E);
        wait_digit("t4_d2", 8'hFB, 8'hFF);
        wait_digit("t4_d0", 8'hFE, 8'hC0);
        wait_digit("t4_d1", 8'hFD, 8'h99);

        // 6: asynchronous reset in the middle of a driven digit
        wait_digit("t6_d2", 8'hFB, 8'hFF);
        chk("t6_cnt_pre", print_cnt, 8'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_an_immediate", an_n, 8'hFF);
        chk("t6_seg_immediate", seg_n, 8'hFF);
        chk("t6_cnt_immediate", print_cnt, 8'd0);
        n_on = 0;
        repeat (5) begin
            @(negedge clk);
            if (an_n != 8'hFF) n_on++;
        end
        chk("t6_no_pulse_in_reset", n_on, 0);
        rst_n = 1'b1;

        // 5: halt pulse together with an ignored strobe, then blink
        do_reset();
        halt = 1; value_valid = 1; value_in = 32'h0000_0007;
        @(negedge clk);
        halt = 0; value_valid = 0;
        chk("t5_strobe_ignored", print_cnt, 8'd0);
        b0 = 0; b1 = 0; b2 = 0;
        repeat (80) begin
            @(negedge clk);
            if (cyc == 3) begin
                chk("t5_d0_an", an_n, 8'hFE);
                chk("t5_d0_dp_seg", seg_n, 8'h40);
            end
            if (an_n != 8'hFF) begin
                if (cyc - 1 <= 20)      b0++;
                else if (cyc - 1 <= 40) b1++;
                else                    b2++;
            end
        end
        chk("t5_on_phase1_driven", b0, 16);
        chk("t5_off_phase_driven", b1, 0);
        chk("t5_after_release_driven", b2, 16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
